// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
//   Load/run controller for the instruction memory. Assembles a little-endian
//   byte stream into 32-bit words and writes them sequentially from word 0.
//   The core is held stalled until the terminator word has been written (or
//   memory is full). After that, the memory port belongs to the core's fetch
//   path.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  one-cycle pulse, (re)load from word 0 (IDLE/RUN only)
//   ld_valid/ld_ready      byte-stream handshake, ld_byte carries the data
//   mem_we/addr/wdata      instruction memory write port, mem_rdata comb read
//   cpu_addr/cpu_instr     core fetch byte address / returned instruction
//   cpu_stall, done        core hold / program running
//   overflow               sticky, memory filled without a terminator
//   word_count             words written by the current/last load
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start; core stalled
// LOAD  | accepting bytes into the assembly register
// WRITE | one cycle, assembled word written to mem[word_ptr]
// RUN   | memory port handed to the core fetch path
module imem_load_ctrl #(
    parameter int          DEPTH            = 256,
    parameter logic [31:0] LAST_INSTRUCTION = 32'h00008067,
    localparam int         AW               = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    output logic          ld_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic [31:0]   cpu_addr,
    output logic [31:0]   cpu_instr,
    output logic          cpu_stall,
    output logic          done,
    output logic          overflow,
    output logic [AW:0]   word_count
);

    localparam logic [31:0]   NOP     = 32'h00000013;
    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] word_ptr;
    logic [1:0]    byte_idx;
    logic [31:0]   asm_word;
    logic          is_last;
    logic          is_full;

    // Byte offset and upper fetch-address bits are deliberately ignored;
    // fetches wrap modulo DEPTH words.
    logic unused_cpu_addr;
    assign unused_cpu_addr = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

    assign is_last   = (asm_word == LAST_INSTRUCTION);
    assign is_full   = (word_ptr == PTR_MAX);
    // The assembly register only changes in LOAD, so it can drive the write
    // data bus directly without gating.
    assign mem_wdata = asm_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        cpu_stall = 1'b1;
        done      = 1'b0;
        mem_addr  = word_ptr;
        cpu_instr = NOP;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && byte_idx == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                if (is_last || is_full) state_nxt = RUN;
                else                    state_nxt = LOAD;
            end
            RUN: begin
                cpu_stall = 1'b0;
                done      = 1'b1;
                mem_addr  = cpu_addr[AW+1:2];
                cpu_instr = mem_rdata;
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_ptr   <= '0;
            byte_idx   <= '0;
            asm_word   <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (start) begin
                        word_ptr   <= '0;
                        byte_idx   <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ld_valid && ld_ready) begin
                        asm_word[{byte_idx, 3'b000} +: 8] <= ld_byte;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    word_count <= word_count + 1'b1;
                    byte_idx   <= '0;
                    if (!is_last) begin
                        if (is_full) overflow <= 1'b1;
                        else         word_ptr <= word_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] LAST = 32'h00008067;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        done;
    logic        overflow;
    logic [8:0]  word_count;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;

    logic [31:0] tb_mem [256];

    imem_load_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_ready   (ld_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .cpu_addr   (cpu_addr),
        .cpu_instr  (cpu_instr),
        .cpu_stall  (cpu_stall),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            tb_mem[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ld_valid = 1'b1;
        ld_byte  = b;
        while (ld_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL ld_ready_timeout waited=%0d limit=50", n);
        end
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    // Returns at the negedge of the WRITE cycle and checks the write port.
    task automatic send_word(input logic [31:0] w, input logic [7:0] addr, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                ld_valid = 1'b0;
                @(negedge clk);
            end
            send_byte(w[8*i +: 8]);
        end
        checks++;
        if (mem_we !== 1'b1) begin
            failures++; $display("FAIL wr_we got=%b exp=1", mem_we);
        end
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++; $display("FAIL wr_ld_ready got=%b exp=0", ld_ready);
        end
        checks++;
        if (mem_addr !== addr) begin
            failures++; $display("FAIL wr_addr got=%0d exp=%0d", mem_addr, addr);
        end
        checks++;
        if (mem_wdata !== w) begin
            failures++; $display("FAIL wr_data got=%h exp=%h", mem_wdata, w);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (ld_ready !== 1'b0) begin failures++; $display("FAIL %s ld_ready got=%b exp=0", tag, ld_ready); end
        checks++;
        if (mem_we !== 1'b0) begin failures++; $display("FAIL %s mem_we got=%b exp=0", tag, mem_we); end
        checks++;
        if (mem_addr !== 8'd0) begin failures++; $display("FAIL %s mem_addr got=%0d exp=0", tag, mem_addr); end
        checks++;
        if (mem_wdata !== 32'h0) begin failures++; $display("FAIL %s mem_wdata got=%h exp=0", tag, mem_wdata); end
        checks++;
        if (cpu_stall !== 1'b1) begin failures++; $display("FAIL %s cpu_stall got=%b exp=1", tag, cpu_stall); end
        checks++;
        if (cpu_instr !== NOP) begin failures++; $display("FAIL %s cpu_instr got=%h exp=%h", tag, cpu_instr, NOP); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL %s done got=%b exp=0", tag, done); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL %s overflow got=%b exp=0", tag, overflow); end
        checks++;
        if (word_count !== 9'd0) begin failures++; $display("FAIL %s word_count got=%0d exp=0", tag, word_count); end
    endtask

    task automatic check_run(input string tag, input logic [8:0] wc, input logic ovf, input int writes);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL %s done got=%b exp=1", tag, done); end
        checks++;
        if (cpu_stall !== 1'b0) begin failures++; $display("FAIL %s cpu_stall got=%b exp=0", tag, cpu_stall); end
        checks++;
        if (word_count !== wc) begin failures++; $display("FAIL %s word_count got=%0d exp=%0d", tag, word_count, wc); end
        checks++;
        if (overflow !== ovf) begin failures++; $display("FAIL %s overflow got=%b exp=%b", tag, overflow, ovf); end
        checks++;
        if (wr_cnt !== writes) begin failures++; $display("FAIL %s writes got=%0d exp=%0d", tag, wr_cnt, writes); end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_byte  = 8'h00;
        cpu_addr = 32'h0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b0) begin failures++; $display("FAIL idle_ld_ready got=%b exp=0", ld_ready); end
    endtask

    task automatic test_basic_load();
        int base;
        base = wr_cnt;
        pulse_start();
        checks++;
        if (ld_ready !== 1'b1) begin failures++; $display("FAIL basic_ld_ready got=%b exp=1", ld_ready); end
        checks++;
        if (cpu_instr !== NOP) begin failures++; $display("FAIL basic_nop got=%h exp=%h", cpu_instr, NOP); end
        send_word(32'h00000013, 8'd0, 1'b0);
        send_word(LAST, 8'd1, 1'b0);
        @(negedge clk);
        check_run("basic", 9'd2, 1'b0, base + 2);
        checks++;
        if (tb_mem[0] !== 32'h00000013) begin failures++; $display("FAIL basic_mem0 got=%h exp=00000013", tb_mem[0]); end
        checks++;
        if (tb_mem[1] !== LAST) begin failures++; $display("FAIL basic_mem1 got=%h exp=%h", tb_mem[1], LAST); end
    endtask

    task automatic test_run_fetch();
        cpu_addr = 32'h0000_0404;
        @(negedge clk);
        checks++;
        if (mem_addr !== 8'd1) begin failures++; $display("FAIL fetch_wrap_addr got=%0d exp=1", mem_addr); end
        checks++;
        if (cpu_instr !== LAST) begin failures++; $display("FAIL fetch_wrap_instr got=%h exp=%h", cpu_instr, LAST); end
        checks++;
        if (mem_we !== 1'b0) begin failures++; $display("FAIL fetch_we got=%b exp=0", mem_we); end
        cpu_addr = 32'hFFFF_FC03;
        @(negedge clk);
        checks++;
        if (mem_addr !== 8'd0) begin failures++; $display("FAIL fetch_hi_addr got=%0d exp=0", mem_addr); end
        checks++;
        if (cpu_instr !== 32'h00000013) begin failures++; $display("FAIL fetch_hi_instr got=%h exp=00000013", cpu_instr); end
    endtask

    task automatic test_toggle_reload();
        int base;
        base = wr_cnt;
        pulse_start();
        checks++;
        if (cpu_stall !== 1'b1) begin failures++; $display("FAIL reload_stall got=%b exp=1", cpu_stall); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reload_done got=%b exp=0", done); end
        checks++;
        if (word_count !== 9'd0) begin failures++; $display("FAIL reload_wc got=%0d exp=0", word_count); end
        send_word(32'h00000013, 8'd0, 1'b1);
        send_word(LAST, 8'd1, 1'b1);
        @(negedge clk);
        check_run("toggle", 9'd2, 1'b0, base + 2);
    endtask

    task automatic test_start_ignored();
        int base;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();
        checks++;
        if (ld_ready !== 1'b1) begin failures++; $display("FAIL ign_ld_ready got=%b exp=1", ld_ready); end
        send_byte(8'h33);
        send_byte(8'h44);
        checks++;
        if (mem_we !== 1'b1) begin failures++; $display("FAIL ign_we got=%b exp=1", mem_we); end
        checks++;
        if (mem_addr !== 8'd0) begin failures++; $display("FAIL ign_addr got=%0d exp=0", mem_addr); end
        checks++;
        if (mem_wdata !== 32'h44332211) begin failures++; $display("FAIL ign_data got=%h exp=44332211", mem_wdata); end
        pulse_start();
        send_word(LAST, 8'd1, 1'b0);
        @(negedge clk);
        check_run("ignored", 9'd2, 1'b0, base + 2);
    endtask

    task automatic test_reset_midload();
        int base;
        pulse_start();
        base = wr_cnt;
        send_word(32'hDDCCBBAA, 8'd0, 1'b0);
        send_byte(8'hEE);
        send_byte(8'hFF);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        checks++;
        if (wr_cnt !== base + 1) begin failures++; $display("FAIL midreset_writes got=%0d exp=%0d", wr_cnt, base + 1); end
        checks++;
        if (tb_mem[0] !== 32'hDDCCBBAA) begin failures++; $display("FAIL midreset_mem0 got=%h exp=ddccbbaa", tb_mem[0]); end
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send_word(LAST, 8'd0, 1'b0);
        @(negedge clk);
        check_run("midreload", 9'd1, 1'b0, base + 2);
        checks++;
        if (tb_mem[0] !== LAST) begin failures++; $display("FAIL midreload_mem0 got=%h exp=%h", tb_mem[0], LAST); end
    endtask

    task automatic test_overflow();
        int base;
        pulse_start();
        base = wr_cnt;
        for (int i = 0; i < 256; i++) begin
            send_word({8'hA5, 8'(i), 16'h1234}, 8'(i), 1'b0);
        end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        @(negedge clk);
        check_run("overflow", 9'd256, 1'b1, base + 256);
        cpu_addr = 32'h0000_03FC;
        @(negedge clk);
        checks++;
        if (cpu_instr !== 32'hA5FF1234) begin failures++; $display("FAIL ovf_fetch got=%h exp=a5ff1234", cpu_instr); end
        pulse_start();
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        checks++;
        if (word_count !== 9'd0) begin failures++; $display("FAIL ovf_wc_clear got=%0d exp=0", word_count); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_run_fetch();
        test_toggle_reload();
        test_start_ignored();
        test_reset_midload();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
